// File: rtl/prog_loader.sv
// prog_loader: receives a byte stream after a start pulse, packs the bytes
// little-endian into 32-bit words and writes them to instruction memory.
// The processor is held in reset for the whole load. A load ends after a
// configurable number of idle cycles. A trailing partial word is written
// zero-padded and flagged. Bytes that arrive once the memory is full are
// dropped and flagged.
module prog_loader #(
   parameter logic [23:0] TIMEOUT_CYCLES = 24'd5_000_000,
   parameter int unsigned MAX_WORDS      = 16384
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        byte_valid,
   input  logic [7:0]  byte_data,
   output logic        mem_we,
   output logic [13:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic        cpu_rst_o,
   output logic        busy,
   output logic        done,
   output logic [14:0] word_count,
   output logic        err_partial,
   output logic        err_overflow
);

   // FSM encoding
   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_LOAD  = 2'd1;
   localparam logic [1:0] ST_FLUSH = 2'd2;
   localparam logic [1:0] ST_DONE  = 2'd3;

   // word_count value at which the memory is full
   localparam logic [14:0] MAX_WC     = 15'(MAX_WORDS);
   // timer value on which an idle cycle ends the load
   localparam logic [23:0] TIMER_LAST = TIMEOUT_CYCLES - 24'd1;

   // Place one byte into its little-endian lane of the word being assembled.
   function automatic logic [31:0] insert_byte(input logic [31:0] word,
                                               input logic [1:0]  idx,
                                               input logic [7:0]  data);
      logic [31:0] res;
      res = word;
      case (idx)
         2'd0:    res[7:0]   = data;
         2'd1:    res[15:8]  = data;
         2'd2:    res[23:16] = data;
         2'd3:    res[31:24] = data;
         default: res        = word;
      endcase
      return res;
   endfunction

   // Keep only the lanes that were actually filled; idx is the count of
   // bytes received for the partial word.
   function automatic logic [31:0] keep_filled(input logic [31:0] word,
                                               input logic [1:0]  idx);
      logic [31:0] res;
      case (idx)
         2'd1:    res = {24'd0, word[7:0]};
         2'd2:    res = {16'd0, word[15:0]};
         2'd3:    res = {8'd0,  word[23:0]};
         default: res = word;
      endcase
      return res;
   endfunction

   logic [1:0]  state_q,        state_d;
   logic [1:0]  byte_idx_q,     byte_idx_d;
   logic [31:0] word_q,         word_d;
   logic [23:0] timer_q,        timer_d;
   logic [14:0] word_count_q,   word_count_d;
   logic        mem_we_q,       mem_we_d;
   logic [13:0] mem_addr_q,     mem_addr_d;
   logic [31:0] mem_wdata_q,    mem_wdata_d;
   logic        busy_q,         busy_d;
   logic        done_q,         done_d;
   logic        err_partial_q,  err_partial_d;
   logic        err_overflow_q, err_overflow_d;

   logic        mem_full_s;
   logic        accept_s;
   logic [31:0] assembled_s;

   // Byte acceptance: only in LOAD and only while the memory has room.
   always_comb begin
      mem_full_s  = (word_count_q == MAX_WC);
      accept_s    = (state_q == ST_LOAD) && byte_valid && !mem_full_s;
      assembled_s = insert_byte(word_q, byte_idx_q, byte_data);
   end

   // Next-state and datapath decisions for the load sequence.
   always_comb begin
      state_d        = state_q;
      byte_idx_d     = byte_idx_q;
      word_d         = word_q;
      timer_d        = timer_q;
      word_count_d   = word_count_q;
      mem_we_d       = 1'b0;
      mem_addr_d     = mem_addr_q;
      mem_wdata_d    = mem_wdata_q;
      err_partial_d  = err_partial_q;
      err_overflow_d = err_overflow_q;

      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               state_d        = ST_LOAD;
               byte_idx_d     = 2'd0;
               word_d         = 32'd0;
               timer_d        = 24'd0;
               word_count_d   = 15'd0;
               err_partial_d  = 1'b0;
               err_overflow_d = 1'b0;
            end else begin
               state_d = state_q;
            end
         end

         ST_LOAD: begin
            if (accept_s) begin
               // an accepted byte always restarts the idle timer, even on
               // the cycle the timer would otherwise expire
               timer_d = 24'd0;
               if (byte_idx_q == 2'd3) begin
                  mem_we_d     = 1'b1;
                  mem_addr_d   = word_count_q[13:0];
                  mem_wdata_d  = assembled_s;
                  word_count_d = word_count_q + 15'd1;
                  byte_idx_d   = 2'd0;
                  word_d       = 32'd0;
               end else begin
                  byte_idx_d = byte_idx_q + 2'd1;
                  word_d     = assembled_s;
               end
            end else begin
               // a byte dropped for lack of space does not count as activity
               if (byte_valid && mem_full_s) begin
                  err_overflow_d = 1'b1;
               end else begin
                  err_overflow_d = err_overflow_q;
               end

               if (timer_q == TIMER_LAST) begin
                  if (byte_idx_q == 2'd0) begin
                     state_d = ST_DONE;
                  end else begin
                     state_d = ST_FLUSH;
                  end
               end else begin
                  timer_d = timer_q + 24'd1;
               end
            end
         end

         ST_FLUSH: begin
            mem_we_d      = 1'b1;
            mem_addr_d    = word_count_q[13:0];
            mem_wdata_d   = keep_filled(word_q, byte_idx_q);
            word_count_d  = word_count_q + 15'd1;
            err_partial_d = 1'b1;
            byte_idx_d    = 2'd0;
            word_d        = 32'd0;
            state_d       = ST_DONE;
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Status flags follow the next state so they change with the state itself.
   always_comb begin
      busy_d = (state_d == ST_LOAD) || (state_d == ST_FLUSH);
      done_d = (state_d == ST_DONE);
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= ST_IDLE;
         byte_idx_q     <= 2'd0;
         word_q         <= 32'd0;
         timer_q        <= 24'd0;
         word_count_q   <= 15'd0;
         mem_we_q       <= 1'b0;
         mem_addr_q     <= 14'd0;
         mem_wdata_q    <= 32'd0;
         busy_q         <= 1'b0;
         done_q         <= 1'b0;
         err_partial_q  <= 1'b0;
         err_overflow_q <= 1'b0;
      end else begin
         state_q        <= state_d;
         byte_idx_q     <= byte_idx_d;
         word_q         <= word_d;
         timer_q        <= timer_d;
         word_count_q   <= word_count_d;
         mem_we_q       <= mem_we_d;
         mem_addr_q     <= mem_addr_d;
         mem_wdata_q    <= mem_wdata_d;
         busy_q         <= busy_d;
         done_q         <= done_d;
         err_partial_q  <= err_partial_d;
         err_overflow_q <= err_overflow_d;
      end
   end

   // Output wiring; the processor reset is deliberately combinational so it
   // asserts in the same cycle as rst.
   always_comb begin
      mem_we       = mem_we_q;
      mem_addr     = mem_addr_q;
      mem_wdata    = mem_wdata_q;
      busy         = busy_q;
      done         = done_q;
      word_count   = word_count_q;
      err_partial  = err_partial_q;
      err_overflow = err_overflow_q;
      cpu_rst_o    = rst | busy_q;
   end

endmodule

// File: tb/tb_prog_loader.sv
// Testbench for prog_loader: directed and random loads, writes checked by a
// scoreboard fed from a byte-level reference model.
module tb_prog_loader;

   localparam logic [23:0] TO = 24'd16;
   localparam int          MW = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic        byte_valid;
   logic [7:0]  byte_data;
   logic        mem_we;
   logic [13:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        cpu_rst_o;
   logic        busy;
   logic        done;
   logic [14:0] word_count;
   logic        err_partial;
   logic        err_overflow;

   prog_loader #(.TIMEOUT_CYCLES(TO), .MAX_WORDS(MW)) dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .byte_valid   (byte_valid),
      .byte_data    (byte_data),
      .mem_we       (mem_we),
      .mem_addr     (mem_addr),
      .mem_wdata    (mem_wdata),
      .cpu_rst_o    (cpu_rst_o),
      .busy         (busy),
      .done         (done),
      .word_count   (word_count),
      .err_partial  (err_partial),
      .err_overflow (err_overflow)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [13:0] addr;
      logic [31:0] data;
   } wr_t;

   int         n_checks = 0;
   int         n_fail   = 0;
   wr_t        exp_q[$];
   logic [7:0] ld_bytes[$];
   int         ld_gaps[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Monitor: every write the DUT presents must match the next expected one.
   always @(negedge clk) begin
      wr_t e;
      if (mem_we === 1'b1) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_write: addr %0d data 0x%08h, none expected", mem_addr, mem_wdata);
         end else begin
            e = exp_q.pop_front();
            check("write_addr", 32'(mem_addr), 32'(e.addr));
            check("write_data", mem_wdata, e.data);
         end
      end
   end

   // Runs one load from ld_bytes/ld_gaps; the model packs bytes little-endian,
   // keeps at most MW words, and pads a trailing partial word with zeros.
   task automatic run_load();
      int          n;
      int          acc;
      int          lat;
      bit          part;
      logic [31:0] cur;
      wr_t         w;
      n = ld_bytes.size();
      start = 1'b1;
      tick();
      start = 1'b0;
      check("busy_after_start", 32'(busy), 32'd1);
      check("cpu_rst_in_load", 32'(cpu_rst_o), 32'd1);
      cur = 32'd0;
      acc = 0;
      for (int i = 0; i < n; i++) begin
         repeat (ld_gaps[i]) tick();
         byte_valid = 1'b1;
         byte_data  = ld_bytes[i];
         if (i < 4 * MW) begin
            cur = cur | (32'(ld_bytes[i]) << (8 * (i % 4)));
            acc++;
            if (i % 4 == 3) begin
               w.addr = 14'(i / 4);
               w.data = cur;
               exp_q.push_back(w);
               cur = 32'd0;
            end
         end
         tick();
         byte_valid = 1'b0;
         check("busy_while_bytes", 32'(busy), 32'd1);
      end
      part = (acc % 4) != 0;
      if (part) begin
         w.addr = 14'(acc / 4);
         w.data = cur;
         exp_q.push_back(w);
      end
      lat = 0;
      while (done !== 1'b1 && lat < 200) begin
         tick();
         lat++;
      end
      check("done_reached", 32'(done), 32'd1);
      if (n <= 4 * MW) begin
         check("done_latency", 32'(lat), 32'(int'(TO) + (part ? 1 : 0)));
      end
      @(negedge clk);
      #1;
      check("word_count", 32'(word_count), 32'(acc / 4 + (part ? 1 : 0)));
      check("err_partial", 32'(err_partial), 32'(part));
      check("err_overflow", 32'(err_overflow), 32'(n > 4 * MW));
      check("busy_in_done", 32'(busy), 32'd0);
      check("cpu_rst_in_done", 32'(cpu_rst_o), 32'd0);
      check("writes_pending", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
      ld_bytes.delete();
      ld_gaps.delete();
      repeat (3) tick();
      check("done_held", 32'(done), 32'd1);
   endtask

   task automatic add_byte(input logic [7:0] b, input int gap);
      ld_bytes.push_back(b);
      ld_gaps.push_back(gap);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      rst        = 1'b1;
      start      = 1'b0;
      byte_valid = 1'b0;
      byte_data  = 8'd0;
      repeat (3) tick();
      check("rst_mem_we", 32'(mem_we), 32'd0);
      check("rst_mem_addr", 32'(mem_addr), 32'd0);
      check("rst_mem_wdata", mem_wdata, 32'd0);
      check("rst_word_count", 32'(word_count), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_err_partial", 32'(err_partial), 32'd0);
      check("rst_err_overflow", 32'(err_overflow), 32'd0);
      check("rst_cpu_rst", 32'(cpu_rst_o), 32'd1);
      rst = 1'b0;
      #1;
      check("idle_cpu_rst", 32'(cpu_rst_o), 32'd0);
      tick();

      // two full instruction words
      add_byte(8'h13, 0); add_byte(8'h00, 0); add_byte(8'h00, 0); add_byte(8'h00, 0);
      add_byte(8'h93, 0); add_byte(8'h00, 0); add_byte(8'h10, 0); add_byte(8'h00, 0);
      run_load();

      // partial trailing word
      add_byte(8'hAA, 0); add_byte(8'hBB, 0); add_byte(8'hCC, 0);
      run_load();

      // overflow: 20 back-to-back bytes into a 4-word memory
      for (int i = 0; i < 20; i++) add_byte(8'(i + 1), 0);
      run_load();

      // bytes landing exactly on the timer's last idle cycle
      add_byte(8'h01, 0); add_byte(8'h02, 15); add_byte(8'h03, 15); add_byte(8'h04, 15);
      add_byte(8'h05, 15);
      run_load();

      // reset in the middle of a word
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < 2; i++) begin
         byte_valid = 1'b1;
         byte_data  = 8'h5A;
         tick();
      end
      byte_valid = 1'b0;
      rst = 1'b1;
      #1;
      check("midload_rst_cpu_rst", 32'(cpu_rst_o), 32'd1);
      tick();
      check("midload_rst_busy", 32'(busy), 32'd0);
      check("midload_rst_word_count", 32'(word_count), 32'd0);
      check("midload_rst_cpu_rst_held", 32'(cpu_rst_o), 32'd1);
      tick();
      rst = 1'b0;
      #1;
      check("after_rst_cpu_rst", 32'(cpu_rst_o), 32'd0);
      repeat (int'(TO) + 4) tick();
      check("after_rst_done", 32'(done), 32'd0);
      check("after_rst_busy", 32'(busy), 32'd0);

      // random loads, each started from DONE (reload)
      for (int k = 0; k < 10; k++) begin
         n = int'($urandom_range(0, 20));
         for (int i = 0; i < n; i++) begin
            if (i >= 4 * MW) add_byte(8'($urandom_range(0, 255)), 0);
            else if ($urandom_range(0, 3) == 0) add_byte(8'($urandom_range(0, 255)), int'($urandom_range(0, 15)));
            else add_byte(8'($urandom_range(0, 255)), 0);
         end
         run_load();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 24'd5_000_000: idle cycles after the last byte that end a load.
REQ-002 Parameter MAX_WORDS, default 16384: instruction memory depth in 32-bit words.
REQ-003 clk  in  1  system clock; all state updates on posedge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 start  in  1  single-cycle pulse that begins a program load.
REQ-006 byte_valid  in  1  byte_data is valid this cycle (one-cycle strobe per byte).
REQ-007 byte_data  in  8  incoming program byte.
REQ-008 mem_we  out  1  instruction-memory write enable, registered.
REQ-009 mem_addr  out  14  instruction-memory word address, registered.
REQ-010 mem_wdata  out  32  instruction-memory write data, registered.
REQ-011 cpu_rst_o  out  1  hold-in-reset for the processor and its fetch PC.
REQ-012 busy  out  1  high in LOAD and FLUSH.
REQ-013 done  out  1  high in DONE.
REQ-014 word_count  out  15  number of words written in the current or last load.
REQ-015 err_partial  out  1  sticky: the load ended on a non-word boundary.
REQ-016 err_overflow  out  1  sticky: a byte arrived after MAX_WORDS words were written.

Function
REQ-017 The FSM SHALL have states IDLE, LOAD, FLUSH and DONE.
REQ-018 From IDLE or DONE, start SHALL enter LOAD next cycle and clear byte index, word_count, timer, err_partial and err_overflow in the same cycle.
REQ-019 start SHALL be ignored in LOAD and FLUSH.
REQ-020 byte_valid SHALL be ignored in IDLE, DONE and FLUSH.
REQ-021 Bytes SHALL be assembled little-endian: byte index 0 to bits[7:0], index 3 to bits[31:24].
REQ-022 When a byte with index 3 is accepted in cycle N, the block SHALL assert mem_we for exactly one cycle in N+1, with mem_addr = word_count[13:0] and the assembled word on mem_wdata; word_count increments in N+1.
REQ-023 The byte index SHALL wrap 3 to 0 after a word completes.
REQ-024 mem_addr and mem_wdata SHALL hold their last values while mem_we is low.
REQ-025 The timer SHALL clear on every accepted byte and increment otherwise in LOAD.
REQ-026 When the timer reaches TIMEOUT_CYCLES-1 with byte index 0, the FSM SHALL go to DONE.
REQ-027 When the timer reaches TIMEOUT_CYCLES-1 with byte index nonzero, the FSM SHALL go to FLUSH.
REQ-028 FLUSH SHALL last one cycle: it writes the partial word with its unfilled upper bytes zeroed, increments word_count, sets err_partial, then goes to DONE.
REQ-029 If byte_valid and timer expiry coincide, the byte SHALL be accepted and the timer SHALL clear; no timeout occurs.
REQ-030 Once word_count equals MAX_WORDS, further bytes SHALL be dropped and set err_overflow; no write occurs and no address wrap occurs.
REQ-031 The timeout SHALL still end the load in the overflow case.
REQ-032 cpu_rst_o SHALL equal rst OR busy (combinational), so the processor is held from reset through the end of FLUSH.
REQ-033 done SHALL remain high in DONE until the next start.

Reset
REQ-034 With rst high at a clock edge, the block SHALL enter IDLE and zero the following: mem_we, mem_addr, mem_wdata, word_count, byte index, timer, done, busy, err_partial, err_overflow.
REQ-035 rst SHALL take priority over start and byte_valid.
REQ-036 rst mid-LOAD SHALL abort the load with no further writes; memory already written is not restored.

Verification (TIMEOUT_CYCLES=16, MAX_WORDS=4)
REQ-037 Load: start, then bytes 13 00 00 00 93 00 10 00 -> mem_we pulses at addr 0 with 0x00000013 and at addr 1 with 0x00100093, each one cycle after the 4th byte; 16 idle cycles later done=1, word_count=2, cpu_rst_o=0.
REQ-038 Partial: start, then bytes AA BB CC, then idle -> FLUSH writes 0x00CCBBAA at addr 0, err_partial=1, word_count=1.
REQ-039 Overflow: start, then 20 bytes -> 4 writes at addrs 0-3, err_overflow=1, word_count=4, no write at addr 0 after addr 3.
REQ-040 Coincidence: a byte arrives on the cycle the timer hits 15 -> byte is accepted, busy stays 1.
REQ-041 Reset: rst asserted after 2 of 4 bytes -> IDLE, no mem_we, busy=0, cpu_rst_o=1 only while rst is high.
REQ-042 Reload: start in DONE -> flags and word_count clear, the next word is written at addr 0.
